// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the single-cycle MIPS front end.
//   state_t              : PC sequencer state encoding (BOOT/RUN/HALTED)
//   DEFAULT_RESET_VECTOR : PC value loaded on reset unless overridden
//   WORD_SHIFT           : byte-to-word shift applied to branch offsets
// ---------------------------------------------------------------------------
package mips_pkg;

   // Two-bit encoding; 2'd3 is unused and recovers to ST_BOOT.
   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam int          WORD_SHIFT           = 2;

endpackage : mips_pkg

// File: rtl/adder_4.sv
// ---------------------------------------------------------------------------
// adder_4
// Constant +4 adder used to form the sequential PC.
//   a : input address
//   y : a + 4, truncated to 32 bits
// ---------------------------------------------------------------------------
module adder_4 (
   input  logic [31:0] a,
   output logic [31:0] y
);

   assign y = a + 32'd4;

endmodule : adder_4

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter controller for the single-cycle MIPS datapath. Owns the PC,
// selects the next PC from sequential/branch/jump targets, and sequences
// boot, fetch stall, halt/resume and a retired-instruction counter.
//
// Ports:
//   clk                : system clock, rising edge
//   reset              : asynchronous active-high reset
//   stall              : freeze PC, state and counter (memory not ready)
//   halt               : current instruction is a halt; enter HALTED
//   resume             : one-cycle pulse, leave HALTED
//   branch_taken       : conditional branch resolved taken
//   branch_offset      : sign-extended word offset
//   jump               : J-type jump
//   jump_index         : J-type 26-bit target field
//   inst_address       : current PC to instruction memory
//   inst_address_plus4 : PC+4 (jal link path), combinational from the PC
//   fetch_valid        : inst_address carries a real instruction
//   halted             : sequencer is in HALTED
//   inst_count         : instructions retired since reset (wraps)
// ---------------------------------------------------------------------------
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int          COUNT_W      = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               halt,
   input  logic               resume,
   input  logic               branch_taken,
   input  logic [31:0]        branch_offset,
   input  logic               jump,
   input  logic [25:0]        jump_index,
   output logic [31:0]        inst_address,
   output logic [31:0]        inst_address_plus4,
   output logic               fetch_valid,
   output logic               halted,
   output logic [COUNT_W-1:0] inst_count
);

   state_t      state;
   logic [31:0] pc4;
   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic [31:0] redirect_pc;

   adder_4 u_adder_4 (
      .a (inst_address),
      .y (pc4)
   );

   assign inst_address_plus4 = pc4;

   // Targets are built from pc4, so they stay word-aligned when the PC is.
   assign jump_target   = {pc4[31:28], jump_index, 2'b00};
   assign branch_target = pc4 + (branch_offset << WORD_SHIFT);

   // Priority below halt: jump beats branch beats sequential.
   // NOTE: every output of a combinational block gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      redirect_pc = pc4;
      if (jump) begin
         redirect_pc = jump_target;
      end else if (branch_taken) begin
         redirect_pc = branch_target;
      end
   end

   // Single FSM block; fetch_valid and halted are registered alongside state.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values and simulation matches the hardware.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_BOOT;
         inst_address <= RESET_VECTOR;
         fetch_valid  <= 1'b0;
         halted       <= 1'b0;
         inst_count   <= '0;
      end else begin
         case (state)
            // One dead cycle after reset; stall is deliberately not consulted.
            ST_BOOT: begin
               state       <= ST_RUN;
               fetch_valid <= 1'b1;
               halted      <= 1'b0;
            end

            ST_RUN: begin
               if (!stall) begin
                  // The halt instruction itself counts as retired.
                  inst_count <= inst_count + COUNT_W'(1);
                  if (halt) begin
                     state       <= ST_HALTED;
                     fetch_valid <= 1'b0;
                     halted      <= 1'b1;
                  end else begin
                     inst_address <= redirect_pc;
                  end
               end
            end

            // Restart at the instruction after the halt.
            ST_HALTED: begin
               if (resume) begin
                  state        <= ST_RUN;
                  inst_address <= pc4;
                  fetch_valid  <= 1'b1;
                  halted       <= 1'b0;
               end
            end

            default: begin
               state       <= ST_BOOT;
               fetch_valid <= 1'b0;
               halted      <= 1'b0;
            end
         endcase
      end
   end

endmodule : pc_sequencer
